// File: rtl/i2c_responder.sv
// I2C target with a 256x8 register file and auto-incrementing pointer.
// SCL/SDA are oversampled on clk; no clock stretching.
module i2c_responder #(
   parameter logic [6:0] DEV_ADDR  = 7'h39,
   parameter logic [7:0] REG_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_stb,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data,
   output logic       busy
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
      ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT_STOP
   } state_t;

   state_t     state_q, state_d;
   logic       scl_s1_q, scl_s2_q, scl_h_q;
   logic       sda_s1_q, sda_s2_q, sda_h_q;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] ptr_q, ptr_d;
   logic       rw_q, rw_d;
   logic       mack_q, mack_d;
   logic       sda_oe_q, sda_oe_d;
   logic       wr_stb_q, wr_stb_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       busy_q, busy_d;
   logic [7:0] dbg_data_q;
   logic [7:0] regs_q [0:255];

   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] rx_byte, rd_byte;

   // Synchronizers track the bus through reset so no phantom edge appears on release.
   always_ff @(posedge clk) begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_in;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
   end

   // An SDA edge only counts as START/STOP when SCL is steady high.
   assign scl_rise  = scl_s2_q & ~scl_h_q;
   assign scl_fall  = ~scl_s2_q & scl_h_q;
   assign start_det = scl_s2_q & scl_h_q & ~sda_s2_q & sda_h_q;
   assign stop_det  = scl_s2_q & scl_h_q & sda_s2_q & ~sda_h_q;
   assign rx_byte   = {shift_q[6:0], sda_s2_q};
   assign rd_byte   = regs_q[ptr_q];

   // Protocol FSM: next state, shifter, pointer and pin-drive decisions.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      rw_d      = rw_q;
      mack_d    = mack_q;
      sda_oe_d  = sda_oe_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (start_det) begin
         state_d  = ST_ADDR;
         cnt_d    = 3'd0;
         sda_oe_d = 1'b0;
      end else if (stop_det) begin
         state_d  = ST_IDLE;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_REG, ST_WDATA: begin
               if (scl_rise) begin
                  shift_d = rx_byte;
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     case (state_q)
                        ST_ADDR: begin
                           rw_d    = sda_s2_q;
                           state_d = (rx_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
                        end
                        ST_REG: begin
                           ptr_d   = rx_byte;
                           state_d = ST_REG_ACK;
                        end
                        default: begin
                           wr_stb_d  = 1'b1;
                           wr_addr_d = ptr_q;
                           wr_data_d = rx_byte;
                           state_d   = ST_WDATA_ACK;
                        end
                     endcase
                  end else begin
                     state_d = state_q;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            // The ACK drive itself marks which of the two falling edges this is.
            ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     cnt_d    = 3'd0;
                     case (state_q)
                        ST_ADDR_ACK: begin
                           if (rw_q) begin
                              state_d  = ST_RDATA;
                              shift_d  = {rd_byte[6:0], 1'b0};
                              sda_oe_d = ~rd_byte[7];
                           end else begin
                              state_d = ST_REG;
                           end
                        end
                        ST_REG_ACK: state_d = ST_WDATA;
                        default: begin
                           state_d = ST_WDATA;
                           ptr_d   = ptr_q + 8'd1;
                        end
                     endcase
                  end
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            ST_RDATA: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     state_d = ST_RDATA_ACK;
                     mack_d  = 1'b0;
                  end else begin
                     state_d = ST_RDATA;
                  end
               end else if (scl_fall) begin
                  sda_oe_d = ~shift_q[7];
                  shift_d  = {shift_q[6:0], 1'b0};
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            ST_RDATA_ACK: begin
               if (scl_rise) begin
                  if (!sda_s2_q) begin
                     mack_d = 1'b1;
                     ptr_d  = ptr_q + 8'd1;
                  end else begin
                     state_d = ST_WAIT_STOP;
                  end
               end else if (scl_fall) begin
                  if (mack_q) begin
                     state_d  = ST_RDATA;
                     cnt_d    = 3'd0;
                     mack_d   = 1'b0;
                     shift_d  = {rd_byte[6:0], 1'b0};
                     sda_oe_d = ~rd_byte[7];
                  end else begin
                     sda_oe_d = 1'b0;
                  end
               end else begin
                  sda_oe_d = sda_oe_q;
               end
            end
            default: state_d = state_q;
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 3'd0;
         shift_q   <= 8'h00;
         ptr_q     <= 8'h00;
         rw_q      <= 1'b0;
         mack_q    <= 1'b0;
         sda_oe_q  <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= 8'h00;
         wr_data_q <= 8'h00;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         rw_q      <= rw_d;
         mack_q    <= mack_d;
         sda_oe_q  <= sda_oe_d;
         wr_stb_q  <= wr_stb_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   // Register file and registered debug read port.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) regs_q[i] <= REG_RESET;
         dbg_data_q <= REG_RESET;
      end else begin
         if (wr_stb_d) regs_q[wr_addr_d] <= wr_data_d;
         dbg_data_q <= regs_q[dbg_addr];
      end
   end

   assign sda_oe   = sda_oe_q;
   assign wr_stb   = wr_stb_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign dbg_data = dbg_data_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_responder.sv
// Bit-banged I2C master driving i2c_responder, checked against a register-file
// model with randomized write/read transactions.
module tb_i2c_responder;
   localparam logic [6:0] DEV = 7'h39;
   localparam int Q = 6;

   logic       clk = 1'b0;
   logic       reset, scl, m_oe, sda_bus;
   logic       sda_oe, wr_stb, busy;
   logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

   logic [7:0]  model_regs [0:255];
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   logic [7:0]  wbuf[$];
   int n_checks = 0, n_fail = 0;
   int stb_long = 0, hi_viol = 0;
   logic any_oe = 1'b0, stb_prev = 1'b0, oe_prev = 1'b0, scl_prev = 1'b0;

   always #5 clk = ~clk;
   assign sda_bus = ~(m_oe | sda_oe);

   i2c_responder #(.DEV_ADDR(DEV), .REG_RESET(8'h00)) dut (
      .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
      .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
   );

   // Bus monitor: capture write strobes, strobe width, and SDA drive changes while SCL is high.
   always @(negedge clk) begin
      if (wr_stb) got_q.push_back({wr_addr, wr_data});
      if (wr_stb && stb_prev) stb_long++;
      if (!reset && scl && scl_prev && (sda_oe != oe_prev)) hi_viol++;
      if (sda_oe) any_oe = 1'b1;
      stb_prev = wr_stb;
      oe_prev  = sda_oe;
      scl_prev = scl;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      m_oe = 1'b0; wait_q(); scl = 1'b1; wait_q(); m_oe = 1'b1; wait_q(); scl = 1'b0; wait_q();
   endtask

   task automatic i2c_stop();
      m_oe = 1'b1; wait_q(); scl = 1'b1; wait_q(); m_oe = 1'b0; wait_q(); wait_q();
   endtask

   task automatic send_bit(input logic b);
      m_oe = ~b; wait_q(); scl = 1'b1; wait_q(); wait_q(); scl = 1'b0; wait_q();
   endtask

   task automatic clock_in(output logic b);
      m_oe = 1'b0; wait_q(); scl = 1'b1; wait_q(); b = sda_bus; wait_q(); scl = 1'b0; wait_q();
   endtask

   task automatic send_byte(input logic [7:0] d, output logic ack_n);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      clock_in(ack_n);
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic nack);
      logic b;
      logic [7:0] v;
      v = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         clock_in(b);
         v[i] = b;
      end
      send_bit(nack);
      d = v;
   endtask

   task automatic compare_stb();
      check_eq("stb_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check_eq("stb_addr_data", {16'h0000, got_q[i]}, {16'h0000, exp_q[i]});
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic dbg_check(input logic [7:0] a);
      dbg_addr = a;
      @(negedge clk); @(negedge clk);
      check_eq("dbg_data", dbg_data, model_regs[a]);
   endtask

   // Writes wbuf starting at register r; the model applies the auto-incrementing pointer.
   task automatic i2c_write(input logic [7:0] r);
      logic ackn;
      logic [7:0] p;
      i2c_start();
      check_eq("busy_start", busy, 1'b1);
      send_byte({DEV, 1'b0}, ackn); check_eq("ack_addr_w", ackn, 1'b0);
      send_byte(r, ackn);           check_eq("ack_reg", ackn, 1'b0);
      p = r;
      foreach (wbuf[i]) begin
         send_byte(wbuf[i], ackn);
         check_eq("ack_data", ackn, 1'b0);
         model_regs[p] = wbuf[i];
         exp_q.push_back({p, wbuf[i]});
         p = p + 8'd1;
      end
      i2c_stop();
      check_eq("busy_stop", busy, 1'b0);
      compare_stb();
   endtask

   // Register read: set pointer, repeated START, read n bytes (last NACKed), optional stray clocks.
   task automatic i2c_read(input logic [7:0] r, input int n, input int extra);
      logic ackn;
      logic [7:0] p, d;
      i2c_start();
      send_byte({DEV, 1'b0}, ackn); check_eq("ack_addr_w", ackn, 1'b0);
      send_byte(r, ackn);           check_eq("ack_reg", ackn, 1'b0);
      i2c_start();
      send_byte({DEV, 1'b1}, ackn); check_eq("ack_addr_r", ackn, 1'b0);
      p = r;
      for (int i = 0; i < n; i++) begin
         recv_byte(d, (i == n - 1));
         check_eq("rd_data", d, model_regs[p]);
         p = p + 8'd1;
      end
      any_oe = 1'b0;
      repeat (extra) send_bit(1'b1);
      if (extra > 0) check_eq("ignore_after_nack", any_oe, 1'b0);
      i2c_stop();
      check_eq("busy_stop", busy, 1'b0);
      compare_stb();
   endtask

   initial begin
      logic ackn;
      logic [7:0] r;
      int n;
      for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
      reset = 1'b1; scl = 1'b1; m_oe = 1'b0; dbg_addr = 8'h41;
      repeat (6) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); @(negedge clk);
      check_eq("rst_sda_oe", sda_oe, 1'b0);
      check_eq("rst_wr_stb", wr_stb, 1'b0);
      check_eq("rst_wr_addr", wr_addr, 8'h00);
      check_eq("rst_wr_data", wr_data, 8'h00);
      check_eq("rst_busy", busy, 1'b0);
      dbg_check(8'h41);
      dbg_check(8'hFF);

      // Write burst
      wbuf = '{8'h10, 8'h00};
      i2c_write(8'h41);
      dbg_check(8'h41);
      check_eq("burst_41", dbg_data, 8'h10);
      dbg_check(8'h42);

      // Register read of 0x98
      wbuf = '{8'h03};
      i2c_write(8'h98);
      i2c_read(8'h98, 1, 0);

      // Address mismatch
      any_oe = 1'b0;
      i2c_start();
      send_byte(8'h70, ackn); check_eq("nack_addr", ackn, 1'b1);
      send_byte(8'hAA, ackn); check_eq("nack_data", ackn, 1'b1);
      check_eq("mismatch_busy", busy, 1'b1);
      i2c_stop();
      check_eq("mismatch_oe", any_oe, 1'b0);
      check_eq("mismatch_busy_p", busy, 1'b0);
      compare_stb();

      // Pointer wrap
      wbuf = '{8'h11, 8'h22};
      i2c_write(8'hFF);
      dbg_check(8'hFF);
      dbg_check(8'h00);
      check_eq("wrap_00", dbg_data, 8'h22);

      // Reset after 4 data bits
      i2c_start();
      send_byte({DEV, 1'b0}, ackn); check_eq("ack_addr_w", ackn, 1'b0);
      send_byte(8'h20, ackn);       check_eq("ack_reg", ackn, 1'b0);
      for (int i = 7; i >= 4; i--) send_bit(1'b1);
      check_eq("pre_reset_busy", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("midrst_sda_oe", sda_oe, 1'b0);
      check_eq("midrst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
      exp_q.delete(); got_q.delete();
      dbg_check(8'h41);
      dbg_check(8'h98);
      m_oe = 1'b0; wait_q(); scl = 1'b1; wait_q(); wait_q();
      check_eq("post_rst_idle", busy, 1'b0);
      wbuf = '{8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255))};
      i2c_write(8'h40);
      dbg_check(8'h41);

      // Sequential read of 0x40..0x42 with ACK, ACK, NACK, then stray clocks before P
      i2c_read(8'h40, 3, 3);

      // Randomized writes and reads
      for (int t = 0; t < 6; t++) begin
         r = 8'($urandom_range(255));
         n = $urandom_range(1, 3);
         wbuf.delete();
         for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom_range(255)));
         i2c_write(r);
         i2c_read(r, n, 0);
         i2c_read(8'($urandom_range(255)), $urandom_range(1, 3), 0);
         dbg_check(r + 8'(n - 1));
      end

      check_eq("oe_change_scl_high", hi_viol, 0);
      check_eq("stb_width", stb_long, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/i2c_responder.md
# i2c_responder

I2C target (slave) model of the ADV7513 configuration port: the receiving end of the bus driven by the design's I2C configuration master. Oversamples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit device address, and serves write and read transactions against an internal 256×8 register file with auto-incrementing pointer. Sits on `i2c_scl`/`i2c_sda` in simulation and loopback benches. It exposes a write-strobe port and a debug read port so checkers can observe the configuration the master applied.

## Interface
Parameters:
- `DEV_ADDR`, 7'h39, 7-bit target address; ADV7513 main map, 8'h72 on the wire for write.
- `REG_RESET`, 8'h00, reset value of every register-file entry.

Ports:
- `clk`  in  1  system clock, at least 16× SCL frequency.
- `reset`  in  1  synchronous, active-high.
- `scl`  in  1  bus clock, input only; no clock stretching.
- `sda_in`  in  1  sampled bus data.
- `sda_oe`  out  1  1 = pull SDA low; the open-drain pad is external.
- `wr_stb`  out  1  one-cycle pulse per committed data byte.
- `wr_addr`  out  8  register index of the committed byte.
- `wr_data`  out  8  committed byte.
- `dbg_addr`  in  8  debug read index.
- `dbg_data`  out  8  register file at `dbg_addr`, registered, 1-cycle latency.
- `busy`  out  1  high from START to STOP/abort.

## Operation
- Input conditioning: `scl` and `sda_in` each pass through a 2-flop synchronizer plus one history flop. Edges are detected on the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Each is valid in any state.
  - START, including a repeated START, goes to ADDR with the bit count cleared.
  - STOP goes to IDLE and releases `sda_oe`.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- Bits are shifted MSB first on the SCL rising edge. A 3-bit counter marks the 8th bit.
- ADDR, after 8 bits:
  - If the upper 7 bits equal `DEV_ADDR`, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP without driving; a mismatch is a NACK.
  - R/W=0 → REG after ACK. R/W=1 → RDATA after ACK, transmitting `regs[ptr]`.
- REG: the received byte loads the 8-bit `ptr`; ACK; then WDATA.
- WDATA, per byte:
  - Write `regs[ptr]`.
  - Pulse `wr_stb` with `wr_addr=ptr` and `wr_data=byte`.
  - ACK, then `ptr ← ptr+1`, wrapping 8'hFF→8'h00.
- RDATA:
  - Drive `sda_oe = ~bit` for each bit.
  - After the 8th bit, release SDA and sample the master ACK on the 9th SCL rising edge.
  - ACK (0): `ptr+1` with wrap, reload the shifter, stay in RDATA.
  - NACK (1): go to WAIT_STOP.
- A write without data bytes followed by a repeated START plus read returns `regs[ptr]`; this is the standard register-read sequence.
- START and STOP in the same sample window are impossible, since both require an SDA edge. If SCL and SDA change in the same sampled cycle, the SCL edge takes precedence and no START/STOP is flagged.

## Timing
- Reset values:
  - `sda_oe=0`, `wr_stb=0`, `wr_addr=0`, `wr_data=0`, `busy=0`.
  - `dbg_data=REG_RESET`, `ptr=0`, state IDLE.
  - All registers = `REG_RESET`.
- Reset mid-transaction: the same rules apply on the next clk edge. `sda_oe` drops immediately, and the responder ignores the bus until a fresh START.
- Detection latency: a pin change is seen as an edge 3 clk cycles later.
- ACK drive:
  - `sda_oe` rises on the detected SCL falling edge that ends bit 8.
  - It falls on the detected SCL falling edge that ends bit 9.
- Read data changes only on detected SCL falling edges, never while SCL is high.
- `wr_stb` asserts for exactly 1 cycle, on the cycle after the 8th data-bit rising edge. It precedes the ACK drive.
- `busy` rises the cycle START is detected and falls the cycle STOP is detected.
- `dbg_data` reflects a write 1 cycle after `wr_stb`.

## Test plan
- Write burst: S, 0x72, 0x41, 0x10, 0x00, P.
  - ACK on all four bytes.
  - `wr_stb` ×2 with (0x41,0x10) then (0x42,0x00).
  - `dbg_addr=0x41` → 0x10.
- Register read: write `regs[0x98]=0x03`, then S 0x72 0x98, Sr 0x73, read 1 byte with NACK, then P.
  - Received byte is 0x03.
  - `sda_oe` never asserts while SCL is high during data.
- Address mismatch: S, 0x70, 0xAA, P.
  - `sda_oe` stays 0 throughout.
  - No `wr_stb`; `busy` falls at P.
- Pointer wrap: write with reg 0xFF, data 0x11, 0x22.
  - `regs[0xFF]=0x11`, `regs[0x00]=0x22`.
- Reset mid-byte: assert `reset` after 4 data bits.
  - `sda_oe=0` and `busy=0` the next cycle, registers back to 0x00.
  - A following full write transaction succeeds.
- Sequential read: three bytes from 0x40 with ACK, ACK, NACK.
  - Returns `regs[0x40..0x42]`.
  - Responder releases SDA after the NACK and ignores SCL until P.
